game_round_engine: RTL and testbench
====================================

# game_round_engine

Round-level controller for the tilt-ball game: sequences level generation, start/pause, per-frame safe-zone checking of up to NUM_BALLS balls, round timer, lives and rating. It sits between the ball positioners and the safe-zone generator, supplying the round-end/win decision, banner selection and scoreboard values to the display path. Successor to the single-ball status logic: multi-ball, with strict and lives modes plus a round timer.

## Interface
- SCREEN_WIDTH, 400, playfield width in pixels; XW = $clog2(SCREEN_WIDTH)
- SCREEN_HEIGHT, 600, playfield height in pixels; YW = $clog2(SCREEN_HEIGHT)
- NUM_BALLS, 2, balls checked per frame (≥1)
- ROUND_TICKS, 1000, frames to survive for a win; TW = $clog2(ROUND_TICKS+1)
- MAX_LIVES, 3, lives per round in lives mode; LW = $clog2(MAX_LIVES+1)
- RATING_WIDTH, 8, rating counter width
- NUM_IMAGES, 4, banner count (≥4)

- clk  in  1  system clock; the block has one clock
- rst  in  1  reset, synchronous, active-high
- i_frame_tick  in  1  one-cycle pulse per frame
- i_ball_x  in  NUM_BALLS*XW  ball k at [k*XW +: XW]
- i_ball_y  in  NUM_BALLS*YW  ball k at [k*YW +: YW]
- i_mode  in  1  0 = strict, 1 = lives; sampled only on READY→RUN
- i_start, i_pause  in  1  one-cycle button pulses
- i_level_rdy  in  1  safe-zone generation complete
- o_regenerate_level  out  1  one-cycle request to safe zone
- o_probe_x / o_probe_y  out  XW / YW  registered safe-zone lookup coordinate
- i_probe_safe  in  1  lookup result, valid 1 cycle after probe
- o_round_ended  out  1  one-cycle pulse on round end
- o_is_win  out  1  result of last round, held
- o_rating  out  RATING_WIDTH  rounds rating
- o_lives  out  LW  remaining lives
- o_time_left  out  TW  remaining frames
- o_game_running  out  1  high in RUN and SCAN
- o_show_banner  out  1  ~o_game_running
- o_banner_num  out  $clog2(NUM_IMAGES)  0 title, 1 win, 2 lose, 3 pause

## Operation
- States: IDLE, GEN, READY, RUN, SCAN, PAUSE, END.
- IDLE → GEN unconditionally; o_regenerate_level pulses during the first GEN cycle.
- GEN: i_level_rdy ignored in the pulse cycle; first later rdy=1 → READY. Banner 0.
- READY: i_start → RUN; load time_left=ROUND_TICKS, lives=MAX_LIVES, latch mode. Banner 0.
- RUN: i_frame_tick → SCAN; otherwise i_pause → PAUSE. Tick and pause in the same cycle: tick wins, and the pause is latched as pending.
- SCAN: probe balls 0..NUM_BALLS-1 on consecutive cycles; count unsafe results (hits). Frame ticks are ignored. A pause during SCAN is latched as pending. Evaluate:
  - strict: hits>0 → lose.
  - lives: hits>0 → lives−1 (once per frame, regardless of hits); lives reaches 0 → lose.
  - no loss: time_left−1; reaches 0 → win.
  - If the round ended → END. Else pending pause → PAUSE. Else → RUN. The pending flag is cleared in all cases.
- PAUSE: timer frozen; i_start → RUN; i_pause ignored. Banner 3.
- END: on entry, o_round_ended pulses and o_is_win is set.
  - Win: rating+1, saturating at 2^RATING_WIDTH−1. Lose: rating−1, saturating at 0.
  - Banner 1/2. i_start → GEN (new regenerate pulse). i_pause ignored.
- start and pause together: start wins in READY, PAUSE and END.
- Rating persists across rounds; only rst clears it.

## Timing
- Reset values: state IDLE; all pulses 0; o_is_win=0; o_rating=0; o_lives=MAX_LIVES; o_time_left=ROUND_TICKS; o_probe_x/y=0; o_game_running=0; o_show_banner=1; o_banner_num=0.
- rst in any state, including mid-SCAN, returns to IDLE in the next cycle with no o_round_ended pulse.
- Tick sampled at edge t: probe k is driven in cycle t+1+k, and its result is sampled at edge t+2+k.
  - Evaluation result (lives, time, state, o_round_ended) is visible in cycle t+2+NUM_BALLS.
  - The frame period must exceed NUM_BALLS+2 cycles.
- All outputs are registered, except o_show_banner.

## Structure
- Package game_pkg: state enum, banner constants (BANNER_TITLE/WIN/LOSE/PAUSE), mode constants.
- Sub-module ball_probe_scanner: muxes ball k onto the probe port, handles the 1-cycle result alignment, and outputs hits plus a done pulse. The FSM, timer, lives and rating stay in the top.

## Test plan
(NUM_BALLS=2, ROUND_TICKS=3, MAX_LIVES=2)
- Reset, rdy held 1 → exactly one regenerate pulse; READY reached at the third cycle after IDLE; banner 0.
- Strict mode, all probes safe, 3 ticks → time 3→2→1→0; END with o_round_ended=1, o_is_win=1, rating 1, banner 1.
- Strict mode, ball 1 unsafe on the first tick → lose at t+4; rating stays 0 (saturating); time_left stays 3.
- Lives mode, both balls unsafe on ticks 1 and 2 → lives 2→1→0; lose after the second frame; one life lost per frame.
- Pause in the same cycle as a tick → SCAN completes, time decrements, then PAUSE; further ticks leave time frozen; start → RUN.
- rst asserted mid-SCAN → IDLE next cycle, rating 0, no round_ended pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the tilt-ball round controller.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_READY,
    ST_RUN,
    ST_SCAN,
    ST_PAUSE,
    ST_END
  } state_t;

  localparam int BANNER_TITLE = 0;
  localparam int BANNER_WIN   = 1;
  localparam int BANNER_LOSE  = 2;
  localparam int BANNER_PAUSE = 3;

  localparam logic MODE_STRICT = 1'b0;
  localparam logic MODE_LIVES  = 1'b1;

endpackage

// File: rtl/game_round_engine_if.sv
// Link between the round engine and the safe-zone generator: level regeneration and per-ball lookup.
interface game_round_engine_if #(
  parameter int XW = 9,
  parameter int YW = 10
);
  logic          o_regenerate_level;
  logic          i_level_rdy;
  logic [XW-1:0] o_probe_x;
  logic [YW-1:0] o_probe_y;
  logic          i_probe_safe;

  modport master (
    output o_regenerate_level, o_probe_x, o_probe_y,
    input  i_level_rdy, i_probe_safe
  );

  modport slave (
    input  o_regenerate_level, o_probe_x, o_probe_y,
    output i_level_rdy, i_probe_safe
  );
endinterface

// File: rtl/ball_probe_scanner.sv
// Walks balls 0..NUM_BALLS-1 onto the probe port one per cycle and counts unsafe lookups;
// done fires in the cycle the last lookup result is present, with hits already including it.
module ball_probe_scanner
  import game_pkg::*;
#(
  parameter int NUM_BALLS = 2,
  parameter int XW        = 9,
  parameter int YW        = 10,
  localparam int HW       = $clog2(NUM_BALLS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_BALLS*XW-1:0] ball_x,
  input  logic [NUM_BALLS*YW-1:0] ball_y,
  input  logic                    probe_safe,
  output logic [XW-1:0]           probe_x,
  output logic [YW-1:0]           probe_y,
  output logic [HW-1:0]           hits,
  output logic                    done
);

  logic          active;
  logic [HW-1:0] idx;
  logic [HW-1:0] hit_acc;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          sample;
  int            sel;

  always_comb begin
    sel    = start ? 0 : int'(idx) + 1;
    next_x = '0;
    next_y = '0;
    for (int k = 0; k < NUM_BALLS; k++) begin
      if (k == sel) begin
        next_x = ball_x[k*XW +: XW];
        next_y = ball_y[k*YW +: YW];
      end
    end
  end

  // idx counts probes issued; from idx=1 on, the result for probe idx-1 is on probe_safe.
  assign sample = active && (idx != '0);
  assign done   = active && (int'(idx) == NUM_BALLS);
  assign hits   = hit_acc + HW'(sample && !probe_safe);

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      idx     <= '0;
      probe_x <= '0;
      probe_y <= '0;
    end else if (start) begin
      active  <= 1'b1;
      idx     <= '0;
      probe_x <= next_x;
      probe_y <= next_y;
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
        if (int'(idx) + 1 < NUM_BALLS) begin
          probe_x <= next_x;
          probe_y <= next_y;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      hit_acc <= '0;
    end else if (sample) begin
      hit_acc <= hits;
    end
  end

endmodule

// File: rtl/game_round_engine.sv
// Round controller: level generation, start/pause, per-frame multi-ball safety scan,
// round timer, lives and persistent rating, plus banner selection for the display path.
module game_round_engine
  import game_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 400,
  parameter int SCREEN_HEIGHT = 600,
  parameter int NUM_BALLS     = 2,
  parameter int ROUND_TICKS   = 1000,
  parameter int MAX_LIVES     = 3,
  parameter int RATING_WIDTH  = 8,
  parameter int NUM_IMAGES    = 4,
  localparam int XW = $clog2(SCREEN_WIDTH),
  localparam int YW = $clog2(SCREEN_HEIGHT),
  localparam int TW = $clog2(ROUND_TICKS + 1),
  localparam int LW = $clog2(MAX_LIVES + 1),
  localparam int BW = $clog2(NUM_IMAGES),
  localparam int HW = $clog2(NUM_BALLS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_frame_tick,
  input  logic [NUM_BALLS*XW-1:0] i_ball_x,
  input  logic [NUM_BALLS*YW-1:0] i_ball_y,
  input  logic                    i_mode,
  input  logic                    i_start,
  input  logic                    i_pause,
  game_round_engine_if.master     zone,
  output logic                    o_round_ended,
  output logic                    o_is_win,
  output logic [RATING_WIDTH-1:0] o_rating,
  output logic [LW-1:0]           o_lives,
  output logic [TW-1:0]           o_time_left,
  output logic                    o_game_running,
  output logic                    o_show_banner,
  output logic [BW-1:0]           o_banner_num
);

  state_t        state;
  logic          regen;
  logic          pause_pend;
  logic          mode;
  logic          scan_start;
  logic          scan_done;
  logic [HW-1:0] scan_hits;
  logic [XW-1:0] probe_x;
  logic [YW-1:0] probe_y;
  logic          hit;
  logic          lose;
  logic          win;
  logic [LW-1:0] lives_next;

  function automatic logic [RATING_WIDTH-1:0] rating_inc(input logic [RATING_WIDTH-1:0] r);
    return (&r) ? r : r + 1'b1;
  endfunction

  function automatic logic [RATING_WIDTH-1:0] rating_dec(input logic [RATING_WIDTH-1:0] r);
    return (r == '0) ? r : r - 1'b1;
  endfunction

  assign scan_start = (state == ST_RUN) && i_frame_tick;

  ball_probe_scanner #(
    .NUM_BALLS(NUM_BALLS),
    .XW       (XW),
    .YW       (YW)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .start     (scan_start),
    .ball_x    (i_ball_x),
    .ball_y    (i_ball_y),
    .probe_safe(zone.i_probe_safe),
    .probe_x   (probe_x),
    .probe_y   (probe_y),
    .hits      (scan_hits),
    .done      (scan_done)
  );

  assign zone.o_probe_x          = probe_x;
  assign zone.o_probe_y          = probe_y;
  assign zone.o_regenerate_level = regen;

  // Frame verdict: a hit frame costs exactly one life in lives mode, whatever the hit count.
  assign hit        = (scan_hits != '0);
  assign lives_next = (mode == MODE_LIVES && hit) ? o_lives - 1'b1 : o_lives;
  assign lose       = hit && (mode == MODE_STRICT || lives_next == '0);
  assign win        = !lose && (o_time_left == TW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      regen          <= 1'b0;
      pause_pend     <= 1'b0;
      mode           <= MODE_STRICT;
      o_round_ended  <= 1'b0;
      o_is_win       <= 1'b0;
      o_rating       <= '0;
      o_lives        <= LW'(MAX_LIVES);
      o_time_left    <= TW'(ROUND_TICKS);
      o_game_running <= 1'b0;
      o_banner_num   <= BW'(BANNER_TITLE);
    end else begin
      regen         <= 1'b0;
      o_round_ended <= 1'b0;
      case (state)
        ST_IDLE: begin
          state        <= ST_GEN;
          regen        <= 1'b1;
          o_banner_num <= BW'(BANNER_TITLE);
        end
        ST_GEN: begin
          if (!regen && zone.i_level_rdy) state <= ST_READY;
        end
        ST_READY: begin
          if (i_start) begin
            state          <= ST_RUN;
            o_time_left    <= TW'(ROUND_TICKS);
            o_lives        <= LW'(MAX_LIVES);
            mode           <= i_mode;
            o_game_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_frame_tick) begin
            state      <= ST_SCAN;
            pause_pend <= i_pause;
          end else if (i_pause) begin
            state          <= ST_PAUSE;
            o_game_running <= 1'b0;
            o_banner_num   <= BW'(BANNER_PAUSE);
          end
        end
        ST_SCAN: begin
          if (i_pause) pause_pend <= 1'b1;
          if (scan_done) begin
            pause_pend <= 1'b0;
            o_lives    <= lives_next;
            if (!lose) o_time_left <= o_time_left - 1'b1;
            if (lose || win) begin
              state          <= ST_END;
              o_round_ended  <= 1'b1;
              o_is_win       <= win;
              o_game_running <= 1'b0;
              o_banner_num   <= win ? BW'(BANNER_WIN) : BW'(BANNER_LOSE);
              o_rating       <= win ? rating_inc(o_rating) : rating_dec(o_rating);
            end else if (pause_pend || i_pause) begin
              state          <= ST_PAUSE;
              o_game_running <= 1'b0;
              o_banner_num   <= BW'(BANNER_PAUSE);
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_PAUSE: begin
          if (i_start) begin
            state          <= ST_RUN;
            o_game_running <= 1'b1;
            o_banner_num   <= BW'(BANNER_TITLE);
          end
        end
        ST_END: begin
          if (i_start) begin
            state        <= ST_GEN;
            regen        <= 1'b1;
            o_banner_num <= BW'(BANNER_TITLE);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_show_banner = ~o_game_running;

endmodule

// File: tb/tb_game_round_engine.sv
// Directed plus randomized bench for game_round_engine with a frame-level reference model.
module tb_game_round_engine;

  localparam int NB = 2;
  localparam int RT = 3;
  localparam int ML = 2;
  localparam int XW = 9;
  localparam int YW = 10;
  localparam int TW = 2;
  localparam int LW = 2;
  localparam int RW = 8;
  localparam int BW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             frame_tick = 1'b0;
  logic             mode = 1'b0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             level_rdy = 1'b1;
  logic [NB*XW-1:0] ball_x = '0;
  logic [NB*YW-1:0] ball_y = '0;

  logic          round_ended, is_win, game_running, show_banner;
  logic [RW-1:0] rating;
  logic [LW-1:0] lives;
  logic [TW-1:0] time_left;
  logic [BW-1:0] banner_num;

  game_round_engine_if #(.XW(XW), .YW(YW)) zone ();

  assign zone.i_level_rdy = level_rdy;

  // Safe-zone model: right half of the playfield is unsafe; answer is one cycle after the probe.
  always @(posedge clk) zone.i_probe_safe <= (zone.o_probe_x < 9'd200);

  game_round_engine #(
    .SCREEN_WIDTH (400),
    .SCREEN_HEIGHT(600),
    .NUM_BALLS    (NB),
    .ROUND_TICKS  (RT),
    .MAX_LIVES    (ML),
    .RATING_WIDTH (RW),
    .NUM_IMAGES   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_frame_tick  (frame_tick),
    .i_ball_x      (ball_x),
    .i_ball_y      (ball_y),
    .i_mode        (mode),
    .i_start       (start),
    .i_pause       (pause),
    .zone          (zone),
    .o_round_ended (round_ended),
    .o_is_win      (is_win),
    .o_rating      (rating),
    .o_lives       (lives),
    .o_time_left   (time_left),
    .o_game_running(game_running),
    .o_show_banner (show_banner),
    .o_banner_num  (banner_num)
  );

  int passed = 0;
  int total  = 0;

  int   m_time, m_lives, m_rating, m_banner;
  logic m_mode, m_win, m_running;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_time = RT; m_lives = ML; m_rating = 0; m_banner = 0;
    m_mode = 1'b0; m_win = 1'b0; m_running = 1'b0;
  endtask

  // One frame's outcome from the game rules, given how many balls sit on unsafe ground.
  task automatic model_frame(input int hits, input bit paused, output bit ended);
    bit lost, won;
    lost = 0; won = 0;
    if (hits > 0) begin
      if (m_mode == 1'b0) lost = 1;
      else begin
        m_lives = m_lives - 1;
        if (m_lives == 0) lost = 1;
      end
    end
    if (!lost) begin
      m_time = m_time - 1;
      won = (m_time == 0);
    end
    ended = lost || won;
    if (ended) begin
      m_win     = won;
      m_rating  = won ? ((m_rating == 255) ? 255 : m_rating + 1) : ((m_rating == 0) ? 0 : m_rating - 1);
      m_running = 1'b0;
      m_banner  = won ? 1 : 2;
    end else if (paused) begin
      m_running = 1'b0;
      m_banner  = 3;
    end else begin
      m_running = 1'b1;
    end
  endtask

  task automatic check_status(input string sfx);
    check({"time", sfx}, time_left, m_time);
    check({"lives", sfx}, lives, m_lives);
    check({"rating", sfx}, rating, m_rating);
    check({"is_win", sfx}, is_win, m_win);
    check({"running", sfx}, game_running, m_running);
    check({"show_banner", sfx}, show_banner, !m_running);
    if (!m_running) check({"banner", sfx}, banner_num, m_banner);
  endtask

  // pz: 0 = no pause, 1 = pause with the tick, 2 = pause during the scan.
  task automatic frame(input int x0, input int x1, input int pz, output bit ended);
    logic [YW-1:0] y0, y1;
    int hits;
    y0 = YW'($urandom_range(0, 599));
    y1 = YW'($urandom_range(0, 599));
    ball_x = {XW'(x1), XW'(x0)};
    ball_y = {y1, y0};
    frame_tick = 1'b1;
    pause = (pz == 1);
    step();
    frame_tick = 1'b0;
    pause = (pz == 2);
    check("probe_x0", zone.o_probe_x, x0);
    check("probe_y0", zone.o_probe_y, y0);
    step();
    pause = 1'b0;
    check("probe_x1", zone.o_probe_x, x1);
    check("time_hold", time_left, m_time);
    step();
    check("ended_early", round_ended, 0);
    step();
    hits = int'(x0 >= 200) + int'(x1 >= 200);
    model_frame(hits, pz != 0, ended);
    check("round_ended", round_ended, ended);
    check_status("");
    step();
    check("ended_pulse", round_ended, 0);
  endtask

  task automatic start_round(input logic md);
    start = 1'b1;
    step();
    start = 1'b0;
    check("regen_on", zone.o_regenerate_level, 1);
    step();
    check("regen_off", zone.o_regenerate_level, 0);
    step();
    mode  = md;
    start = 1'b1;
    step();
    start = 1'b0;
    mode  = ~md;
    m_mode = md; m_time = RT; m_lives = ML; m_running = 1'b1;
    check_status("_start");
  endtask

  task automatic resume();
    start = 1'b1;
    step();
    start = 1'b0;
    m_running = 1'b1;
    check("resume_run", game_running, 1);
  endtask

  initial begin
    int  regen_cnt;
    int  ended_cnt;
    bit  ended;
    int  x0, x1, r, pz;

    model_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_ended", round_ended, 0);
    check("rst_probe_x", zone.o_probe_x, 0);
    check("rst_probe_y", zone.o_probe_y, 0);
    check("rst_regen", zone.o_regenerate_level, 0);
    check_status("_rst");

    regen_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      regen_cnt += int'(zone.o_regenerate_level);
    end
    check("regen_count", regen_cnt, 1);
    check("ready_banner", banner_num, 0);
    mode  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    m_mode = 1'b0; m_running = 1'b1;
    check("ready_to_run", game_running, 1);

    // strict win
    frame(10, 20, 0, ended);
    frame(150, 199, 0, ended);
    frame(0, 5, 0, ended);
    pause = 1'b1;
    step();
    pause = 1'b0;
    check("end_pause_ignored", banner_num, 1);

    // strict losses, second one saturates rating at 0
    start_round(1'b0);
    frame(50, 300, 0, ended);
    start_round(1'b0);
    frame(250, 50, 0, ended);

    // lives mode, both balls unsafe twice
    start_round(1'b1);
    frame(300, 300, 0, ended);
    frame(210, 399, 0, ended);

    // pause together with a tick, ticks frozen while paused, start beats pause
    start_round(1'b0);
    frame(5, 5, 1, ended);
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      step();
      check("pause_time_frozen", time_left, m_time);
    end
    pause = 1'b1;
    step();
    pause = 1'b0;
    check("pause_pause_ignored", game_running, 0);
    start = 1'b1;
    pause = 1'b1;
    step();
    start = 1'b0;
    pause = 1'b0;
    m_running = 1'b1;
    check("pause_start_wins", game_running, 1);

    // randomized frames across rounds and modes
    for (int i = 0; i < 24; i++) begin
      x0 = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 399) : $urandom_range(0, 199);
      x1 = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 399) : $urandom_range(0, 199);
      r  = $urandom_range(0, 5);
      pz = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      frame(x0, x1, pz, ended);
      if (ended) start_round(1'($urandom_range(0, 1)));
      else if (pz != 0) resume();
    end

    // reset in the middle of a scan
    ball_x = {XW'(33), XW'(77)};
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check("midscan_ended", round_ended, 0);
    check("midscan_probe_x", zone.o_probe_x, 0);
    check_status("_midscan");
    ended_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      ended_cnt += int'(round_ended);
    end
    check("midscan_no_end_pulse", ended_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
